// File: rtl/sys_reg_file_if.sv
// Command/response bus between the system controller and the register file.
`default_nettype none

interface sys_reg_file_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output wr_en, rd_en, addr, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, rd_en, addr, wr_data,
    output rd_data, rd_valid
  );
endinterface

`default_nettype wire

// File: rtl/sys_reg_file.sv
// ============================================================================
// Module   : sys_reg_file
// Purpose  : Controller-facing register file; locations 0-3 drive ALU operands,
//            UART config and clock-divider ratio continuously.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  sys_reg_file_if.slave              bus,
  output logic      [DATA_WIDTH-1:0] reg0,
  output logic      [DATA_WIDTH-1:0] reg1,
  output logic      [DATA_WIDTH-1:0] reg2,
  output logic      [DATA_WIDTH-1:0] reg3
);

  // DEPTH must be at least 4 so the dedicated outputs exist.
  localparam int                    IDX_W        = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CMP    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] UART_CFG_RST = DATA_WIDTH'(8'h81);
  localparam logic [DATA_WIDTH-1:0] CLK_DIV_RST  = DATA_WIDTH'(8'h20);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  do_write;
  logic                  do_read;

  function automatic logic [DATA_WIDTH-1:0] reset_value(input int loc);
    case (loc)
      2:       return UART_CFG_RST;
      3:       return CLK_DIV_RST;
      default: return '0;
    endcase
  endfunction

  assign in_range = ({1'b0, bus.addr} < DEPTH_CMP);
  assign idx      = bus.addr[IDX_W-1:0];
  // Simultaneous write and read is an illegal request: both are dropped.
  assign do_write = bus.wr_en && !bus.rd_en && in_range;
  assign do_read  = bus.rd_en && !bus.wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= reset_value(i);
      end
    end else if (do_write) begin
      mem[idx] <= bus.wr_data;
    end
  end

  // Out-of-range reads still pulse valid so the controller never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_read;
      if (do_read) begin
        rd_data_q <= in_range ? mem[idx] : '0;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

  assign reg0 = mem[0];
  assign reg1 = mem[1];
  assign reg2 = mem[2];
  assign reg3 = mem[3];

endmodule

`default_nettype wire
